// File: rtl/cpu_run_dump_ctrl_if.sv
// Dump stream between the run/dump controller and its consumer.
// Each beat carries one word, tagged as a register (kind 0) or a memory word (kind 1).
interface cpu_run_dump_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 6
);
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_kind;
  logic [IDX_W-1:0]      out_index;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output out_valid,
    output out_kind,
    output out_index,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_kind,
    input  out_index,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/cpu_run_dump_ctrl.sv
// Run/dump controller for the single-cycle MIPS harness.
// Gates the CPU for a programmed number of cycles (or until a halt request),
// then streams out the register file and the data memory one word per beat.
module cpu_run_dump_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int MEM_WORDS  = 64,
  parameter int CYCLE_W    = 32,
  parameter int IDX_W      = $clog2((REG_COUNT > MEM_WORDS) ? REG_COUNT : MEM_WORDS),
  parameter int RA_W       = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CYCLE_W-1:0]    cycle_limit,
  input  logic                  halt_req,
  output logic                  cpu_en,
  output logic [RA_W-1:0]       dbg_reg_a,
  input  logic [DATA_WIDTH-1:0] dbg_reg_rd,
  output logic [31:0]           dbg_mem_a,
  input  logic [DATA_WIDTH-1:0] dbg_mem_rd,
  cpu_run_dump_ctrl_if.master   dump,
  output logic                  busy,
  output logic                  done,
  output logic [CYCLE_W-1:0]    cycles_run
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DREG  = 3'd2;
  localparam logic [2:0] S_DMEM  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(REG_COUNT - 1);
  localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_WORDS - 1);

  logic [2:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CYCLE_W-1:0] cyc_q, cyc_d;
  logic [CYCLE_W-1:0] limit_q, limit_d;

  logic in_run, in_dreg, in_dmem, beat_hs;

  assign in_run  = (state_q == S_RUN);
  assign in_dreg = (state_q == S_DREG);
  assign in_dmem = (state_q == S_DMEM);
  assign beat_hs = (in_dreg || in_dmem) && dump.out_ready;

  // Next-state, index, cycle counter and latched limit
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cyc_d   = cyc_q;
    limit_d = limit_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          limit_d = cycle_limit;
          cyc_d   = '0;
          idx_d   = '0;
          state_d = (cycle_limit != '0) ? S_RUN : S_DREG;
        end
      end
      S_RUN: begin
        // A halted cycle has the CPU frozen, so it is not counted.
        if (halt_req) begin
          state_d = S_DREG;
          idx_d   = '0;
        end else begin
          if (cyc_q != limit_q) cyc_d = cyc_q + CYCLE_W'(1);
          if (cyc_d == limit_q) begin
            state_d = S_DREG;
            idx_d   = '0;
          end
        end
      end
      S_DREG: begin
        if (beat_hs) begin
          if (idx_q == REG_LAST) begin
            state_d = S_DMEM;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_DMEM: begin
        if (beat_hs) begin
          if (idx_q == MEM_LAST) state_d = S_DONE;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset aborts any run or dump
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cyc_q   <= '0;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
      limit_q <= limit_d;
    end
  end

  // Combinational outputs; the CPU is frozen outside RUN so dump data is stable
  assign cpu_en     = in_run && !halt_req;
  assign busy       = in_run || in_dreg || in_dmem;
  assign done       = (state_q == S_DONE);
  assign cycles_run = cyc_q;

  assign dbg_reg_a  = in_dreg ? idx_q[RA_W-1:0] : '0;
  assign dbg_mem_a  = in_dmem ? {{(30-IDX_W){1'b0}}, idx_q, 2'b00} : 32'd0;

  assign dump.out_valid = in_dreg || in_dmem;
  assign dump.out_kind  = in_dmem;
  assign dump.out_index = idx_q;
  assign dump.out_data  = in_dmem ? dbg_mem_rd : (in_dreg ? dbg_reg_rd : '0);

endmodule

// File: doc/cpu_run_dump_ctrl.md
Name: cpu_run_dump_ctrl

Overview:
Sequential run/dump controller for the single-cycle MIPS CPU harness. It replaces fixed-count clock loops and hierarchical register/memory peeks.
- Enables the CPU for a programmable number of cycles, or until an early halt request.
- Then streams the register file and the data memory contents out over a valid/ready interface, one word per beat.
- Sits between the bench/top level and the CPU's clock-enable, a spare register-file read port and a data-memory read port.

Parameters:
DATA_WIDTH, 32, width of register and memory words
REG_COUNT, 32, number of registers dumped (power of two)
MEM_WORDS, 64, number of data-memory words dumped
CYCLE_W, 32, width of cycle limit/counter
IDX_W, $clog2(max(REG_COUNT,MEM_WORDS)), width of dump index

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin run; sampled only in IDLE or DONE
cycle_limit  input  CYCLE_W  CPU cycles to run; latched on accepted start
halt_req  input  1  early stop request from CPU/bench
cpu_en  output  1  enable for PC flop, register-file we3 and data-memory we
dbg_reg_a  output  $clog2(REG_COUNT)  register-file read address
dbg_reg_rd  input  DATA_WIDTH  register-file read data (combinational)
dbg_mem_a  output  32  data-memory byte address
dbg_mem_rd  input  DATA_WIDTH  data-memory read data (combinational)
out_valid  output  1  dump beat valid
out_ready  input  1  consumer accepts beat
out_kind  output  1  0 = register, 1 = memory
out_index  output  IDX_W  register number or memory word index
out_data  output  DATA_WIDTH  dumped word
busy  output  1  high in RUN, DUMP_REG, DUMP_MEM
done  output  1  high in DONE
cycles_run  output  CYCLE_W  CPU-enabled cycles in the current/last run

Behaviour:
- States: IDLE, RUN, DUMP_REG, DUMP_MEM, DONE. Encoding is free.
- Reset (sync, active-high): next edge forces IDLE, with
  - index = 0, cycles_run = 0, cycle count = 0;
  - cpu_en = 0, out_valid = 0, busy = 0, done = 0.
  - Reset mid-RUN or mid-dump aborts immediately. No partial beat is completed after the reset edge.
- IDLE/DONE + start = 1 at an edge:
  - latch cycle_limit and clear cycles_run and index;
  - go to RUN if latched limit != 0, else go directly to DUMP_REG.
  - DONE holds done = 1 until a start is accepted.
- start in any busy state is ignored; the latched limit is unchanged.
- RUN:
  - cpu_en = !halt_req (combinational);
  - every cycle with cpu_en = 1 increments cycles_run;
  - leave to DUMP_REG at the edge where cycles_run reaches the limit (cpu_en high exactly `limit` cycles), or at the edge of a cycle with halt_req = 1. That cycle has cpu_en = 0 and is not counted.
  - halt_req is ignored outside RUN.
- cpu_en = 0 in all states other than RUN, so CPU state is frozen during the dump.
- DUMP_REG:
  - out_valid = 1, out_kind = 0, out_index = index;
  - dbg_reg_a = index, out_data = dbg_reg_rd (combinational pass-through, stable because the CPU is frozen);
  - on out_valid & out_ready: if index == REG_COUNT-1, go to DUMP_MEM with index = 0; else index + 1.
- DUMP_MEM:
  - out_kind = 1;
  - dbg_mem_a = index*4, zero-extended to 32 bits;
  - out_data = dbg_mem_rd;
  - on handshake: if index == MEM_WORDS-1, go to DONE; else index + 1.
- Backpressure: while out_ready = 0, out_valid stays 1 and out_index/out_data stay stable. No beat is skipped or duplicated.
- Address outputs in non-dump states: dbg_reg_a = 0, dbg_mem_a = 0.
- Counters: cycles_run saturates at the limit and never wraps. A full run is exactly REG_COUNT + MEM_WORDS beats.

Test Plan:
1. reset, start with limit = 5, out_ready = 1 → cpu_en high exactly 5 consecutive cycles, cycles_run = 5. Then 32 beats kind 0 with indexes 0..31, then 64 beats kind 1 with dbg_mem_a 0,4,…,252. done = 1 after beat 96; out_data matches preloaded reg/mem values.
2. limit = 0 → cpu_en never asserted, cycles_run = 0, first beat (reg 0) valid one cycle after start.
3. limit = 100, halt_req raised in the 4th RUN cycle → cpu_en high 3 cycles, cycles_run = 3, dump starts next cycle.
4. out_ready toggling 1,0,0,1 pattern during the dump → each index appears exactly once in accepted beats, stable while stalled, 96 accepts total.
5. start pulsed again in RUN and DUMP_MEM → ignored. Reset asserted mid-DUMP_MEM → next cycle IDLE with all outputs 0. New start from DONE restarts with cycles_run cleared.
